// File: rtl/rr_arb_mux_pkg.sv
// rtl/rr_arb_mux_pkg.sv - shared constants and helpers for the arbitrated mux
package rr_arb_mux_pkg;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Index width, never narrower than one bit so N_CH=1 still has a port.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - producer/consumer handshake bundle for rr_arb_mux
interface rr_arb_mux_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    import rr_arb_mux_pkg::*;

    localparam int SEL_W = sel_width(N_CH);

    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// rtl/rr_arb_mux_arbiter.sv - round-robin / fixed-priority arbiter, double-width masked encoder
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] idx
);

    logic [N_CH-1:0]   req_lo;
    logic [2*N_CH-1:0] req_dbl;
    logic              found;

    // Lower copy keeps only requests at or above ptr; the upper copy supplies the wrap.
    always_comb begin
        req_lo  = '0;
        req_dbl = '0;
        found   = 1'b0;
        idx     = '0;
        grant   = '0;
        for (int i = 0; i < N_CH; i++) begin
            req_lo[i] = req[i] & ((mode == ARB_FIXED) || (i >= int'(ptr)));
        end
        req_dbl = {req, req_lo};
        for (int j = 0; j < 2*N_CH; j++) begin
            if (!found && req_dbl[j]) begin
                found = 1'b1;
                idx   = (j >= N_CH) ? SEL_W'(j - N_CH) : SEL_W'(j);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            grant[i] = found && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel arbitrated mux with one registered output stage
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 8,
    parameter int RR_MODE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb_mux_if.slave  bus
);

    localparam int   SEL_W = sel_width(N_CH);
    localparam logic MODE  = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    logic [SEL_W-1:0] ptr;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] sel_data;
    logic             load;
    logic             xfer;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel_q;

    rr_arbiter #(.N_CH(N_CH)) u_arbiter (
        .req   (bus.in_valid),
        .ptr   (ptr),
        .mode  (MODE),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign load         = ~valid_q | bus.out_ready;
    assign bus.in_ready = rst_n ? (grant & {N_CH{load}}) : '0;
    assign xfer         = |(bus.in_valid & bus.in_ready);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_data = sel_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            valid_q <= 1'b1;
            data_q  <= sel_data;
            sel_q   <= grant_idx;
            if (MODE == ARB_RR) begin
                ptr <= (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - directed self-checking bench for rr_arb_mux
module tb_rr_arb_mux;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rr_arb_mux_if #(.N_CH(4), .WIDTH(8)) bus_rr ();
    rr_arb_mux_if #(.N_CH(4), .WIDTH(8)) bus_fp ();

    rr_arb_mux #(.N_CH(4), .WIDTH(8), .RR_MODE(1)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_rr)
    );

    rr_arb_mux #(.N_CH(4), .WIDTH(8), .RR_MODE(0)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_sel [6];
        checks   = 0;
        failures = 0;
        exp_sel  = '{3, 0, 1, 2, 3, 0};

        rst_n            = 1'b0;
        bus_rr.in_valid  = 4'b1111;
        bus_rr.in_data   = '0;
        bus_rr.out_ready = 1'b1;
        bus_fp.in_valid  = 4'b0000;
        bus_fp.in_data   = '0;
        bus_fp.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_valid", bus_rr.out_valid, 0);
        chk("reset_data", bus_rr.out_data, 8'h00);
        chk("reset_sel", bus_rr.out_sel, 0);
        chk("reset_in_ready", bus_rr.in_ready, 4'b0000);
        @(negedge clk);

        // single channel 2
        bus_rr.in_valid = 4'b0000;
        rst_n           = 1'b1;
        @(negedge clk);
        bus_rr.in_valid = 4'b0100;
        bus_rr.in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        #1;
        chk("single_in_ready", bus_rr.in_ready, 4'b0100);
        step();
        chk("single_valid", bus_rr.out_valid, 1);
        chk("single_data", bus_rr.out_data, 8'hA5);
        chk("single_sel", bus_rr.out_sel, 2);

        // all valid: ptr=3 so channel 3 is next
        bus_rr.in_valid = 4'b1111;
        bus_rr.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        chk("rr_first_in_ready", bus_rr.in_ready, 4'b1000);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_valid", bus_rr.out_valid, 1);
            chk("rr_sel", bus_rr.out_sel, exp_sel[k]);
            chk("rr_data", bus_rr.out_data, 8'h10 + exp_sel[k]);
        end

        // backpressure
        bus_rr.out_ready = 1'b0;
        #1;
        chk("bp_in_ready", bus_rr.in_ready, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_valid", bus_rr.out_valid, 1);
            chk("bp_sel", bus_rr.out_sel, 0);
            chk("bp_data", bus_rr.out_data, 8'h10);
            chk("bp_stall_in_ready", bus_rr.in_ready, 4'b0000);
        end
        bus_rr.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", bus_rr.in_ready, 4'b0010);
        step();
        chk("bp_release_sel", bus_rr.out_sel, 1);
        chk("bp_release_data", bus_rr.out_data, 8'h11);

        // asynchronous reset mid-run with a word in flight
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus_rr.out_valid, 0);
        chk("midrst_data", bus_rr.out_data, 8'h00);
        chk("midrst_sel", bus_rr.out_sel, 0);
        chk("midrst_in_ready", bus_rr.in_ready, 4'b0000);
        rst_n = 1'b1;
        #1;
        chk("midrst_scan_from0", bus_rr.in_ready, 4'b0001);
        step();
        chk("midrst_first_sel", bus_rr.out_sel, 0);
        chk("midrst_first_data", bus_rr.out_data, 8'h10);

        // wrap: grant 2 -> ptr=3, then only channel 0 requests
        bus_rr.in_valid = 4'b0100;
        step();
        chk("wrap_pre_sel", bus_rr.out_sel, 2);
        bus_rr.in_valid = 4'b0001;
        bus_rr.in_data  = {8'h13, 8'h12, 8'h11, 8'h3C};
        #1;
        chk("wrap_in_ready", bus_rr.in_ready, 4'b0001);
        step();
        chk("wrap_sel", bus_rr.out_sel, 0);
        chk("wrap_data", bus_rr.out_data, 8'h3C);

        // idle drain holds data; ptr stays at 1
        bus_rr.in_valid = 4'b0000;
        step();
        chk("idle_valid", bus_rr.out_valid, 0);
        chk("idle_data", bus_rr.out_data, 8'h3C);
        chk("idle_sel", bus_rr.out_sel, 0);
        step();
        chk("idle2_valid", bus_rr.out_valid, 0);
        bus_rr.in_valid = 4'b0011;
        #1;
        chk("ptr_after_wrap", bus_rr.in_ready, 4'b0010);
        step();
        chk("ptr_after_wrap_sel", bus_rr.out_sel, 1);
        bus_rr.in_valid = 4'b0000;

        // fixed priority instance
        bus_fp.in_valid = 4'b1010;
        bus_fp.in_data  = {8'h23, 8'h22, 8'h21, 8'h20};
        #1;
        chk("fp_in_ready", bus_fp.in_ready, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fp_valid", bus_fp.out_valid, 1);
            chk("fp_sel", bus_fp.out_sel, 1);
            chk("fp_data", bus_fp.out_data, 8'h21);
        end
        bus_fp.in_valid = 4'b1000;
        #1;
        chk("fp_ch3_in_ready", bus_fp.in_ready, 4'b1000);
        step();
        chk("fp_ch3_sel", bus_fp.out_sel, 3);
        chk("fp_ch3_data", bus_fp.out_data, 8'h23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
